// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - Fetch-stage program counter with branch/load/trap redirect and circular return-address stack
//
// Ports:
//   clk, reset_n         rising-edge clock, asynchronous active-low reset
//   stall                freeze PC and RAS (trap still wins)
//   trap                 force PC to TRAP_VEC
//   sel_addr/loaded_addr absolute redirect
//   br_taken/incr        PC-relative redirect, incr is a signed byte offset
//   call                 with a redirect, push pc_seq onto the RAS
//   ret                  pop RAS top as target (acts as inc_pc when RAS empty)
//   inc_pc               sequential advance by ILEN_BYTES
//   pc_res               registered fetch address
//   pc_seq               pc_res + ILEN_BYTES
//   misaligned           registered pulse after a rejected misaligned target
//   ras_empty/ras_full   RAS occupancy flags
module pc_unit #(
    parameter int unsigned            XLEN       = 32,
    parameter logic [XLEN-1:0]        RESET_VEC  = '0,
    parameter logic [XLEN-1:0]        TRAP_VEC   = 'h100,
    parameter int unsigned            RAS_DEPTH  = 4,
    parameter int unsigned            ILEN_BYTES = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            trap,
    input  logic            sel_addr,
    input  logic [XLEN-1:0] loaded_addr,
    input  logic            br_taken,
    input  logic [XLEN-1:0] incr,
    input  logic            call,
    input  logic            ret,
    input  logic            inc_pc,
    output logic [XLEN-1:0] pc_res,
    output logic [XLEN-1:0] pc_seq,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr;     // next slot to write; top entry sits just below it
    logic [CW-1:0]   count;

    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] target;
    logic            mis_next;
    logic            push;
    logic            pop;
    logic [PW-1:0]   top_idx;

    assign pc_seq    = pc_res + XLEN'(ILEN_BYTES);
    assign ras_empty = (count == '0);
    assign ras_full  = (count == FULL_CNT);
    assign top_idx   = wr_ptr - 1'b1;

    always_comb begin
        pc_next  = pc_res;
        target   = pc_res;
        mis_next = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        if (trap) begin
            pc_next = TRAP_VEC;
        end else if (stall) begin
            pc_next = pc_res;
        end else if (sel_addr || br_taken || (ret && !ras_empty)) begin
            if (sel_addr)
                target = loaded_addr;
            else if (br_taken)
                target = pc_res + incr;
            else
                target = ras[top_idx];
            if (target[1:0] != 2'b00) begin
                // Rejected target: divert to trap, leave the RAS untouched
                pc_next  = TRAP_VEC;
                mis_next = 1'b1;
            end else begin
                pc_next = target;
                // ret alongside a redirect is ignored; only the push happens
                push    = (sel_addr || br_taken) && call;
                pop     = !(sel_addr || br_taken);
            end
        end else if (inc_pc || ret) begin
            pc_next = pc_seq;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_res     <= RESET_VEC;
            wr_ptr     <= '0;
            count      <= '0;
            misaligned <= 1'b0;
        end else begin
            pc_res     <= pc_next;
            misaligned <= mis_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                // When full, the write slot holds the oldest entry, so it is overwritten
                if (!ras_full)
                    count <= count + 1'b1;
            end else if (pop) begin
                wr_ptr <= top_idx;
                count  <= count - 1'b1;
            end
        end
    end

    // Entry contents need no reset
    always_ff @(posedge clk) begin
        if (push)
            ras[wr_ptr] <= pc_seq;
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - Randomized and directed check of pc_unit against a queue-based reference model
module tb_pc_unit;

    localparam logic [31:0] TRAP = 32'h100;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 0, trap = 0, sel_addr = 0, br_taken = 0, call = 0, ret = 0, inc_pc = 0;
    logic [31:0] loaded_addr = '0, incr = '0;
    logic [31:0] pc_res, pc_seq;
    logic        misaligned, ras_empty, ras_full;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic        m_mis;
    logic [31:0] m_ras [$];

    pc_unit dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .trap(trap),
        .sel_addr(sel_addr), .loaded_addr(loaded_addr), .br_taken(br_taken),
        .incr(incr), .call(call), .ret(ret), .inc_pc(inc_pc),
        .pc_res(pc_res), .pc_seq(pc_seq), .misaligned(misaligned),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, pc_res, m_pc);
        check({tag, ".seq"}, pc_seq, m_pc + 32'd4);
        check({tag, ".mis"}, {31'b0, misaligned}, {31'b0, m_mis});
        check({tag, ".empty"}, {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
        check({tag, ".full"}, {31'b0, ras_full}, {31'b0, m_ras.size() == DEPTH});
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_mis = 1'b0;
        m_ras.delete();
    endtask

    // Reference: a bounded list of return addresses, newest at the back
    task automatic model_step();
        logic [31:0] tgt;
        logic        redirect;
        m_mis = 1'b0;
        redirect = sel_addr || br_taken;
        if (trap) begin
            m_pc = TRAP;
        end else if (stall) begin
        end else if (redirect || (ret && m_ras.size() > 0)) begin
            if (sel_addr)      tgt = loaded_addr;
            else if (br_taken) tgt = m_pc + incr;
            else               tgt = m_ras[$];
            if (tgt % 4 != 0) begin
                m_pc  = TRAP;
                m_mis = 1'b1;
            end else begin
                if (redirect && call) begin
                    m_ras.push_back(m_pc + 32'd4);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end else if (!redirect) begin
                    void'(m_ras.pop_back());
                end
                m_pc = tgt;
            end
        end else if (inc_pc || ret) begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic clear_in();
        stall = 0; trap = 0; sel_addr = 0; br_taken = 0; call = 0; ret = 0; inc_pc = 0;
        loaded_addr = '0; incr = '0;
    endtask

    task automatic cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        clear_in();
    endtask

    task automatic do_sel(input logic [31:0] a, input logic c, input string tag);
        sel_addr = 1; loaded_addr = a; call = c; cycle(tag);
    endtask

    initial begin
        model_reset();
        #3;
        check_all("reset");
        #4;
        reset_n = 1'b1;

        repeat (3) begin inc_pc = 1; cycle("inc"); end
        check("inc_to_c", pc_res, 32'hC);

        do_sel(32'h20, 0, "sel20");
        do_sel(32'h200, 1, "call200");
        check("call_pc", pc_res, 32'h200);
        ret = 1; cycle("ret24");
        check("ret_pc", pc_res, 32'h24);

        do_sel(32'h100, 0, "sel100");
        br_taken = 1; incr = 32'hFFFF_FFF8; cycle("br_neg");
        check("br_neg_pc", pc_res, 32'hF8);
        br_taken = 1; incr = 32'h2; cycle("br_mis");
        check("br_mis_flag", {31'b0, misaligned}, 32'h1);
        inc_pc = 1; cycle("mis_clear");

        for (int i = 1; i <= 5; i++) do_sel(32'h1000 * i, 1, "call5");
        for (int i = 0; i < 5; i++) begin ret = 1; cycle("ret5"); end

        // call+ret with redirect: push only
        sel_addr = 1; loaded_addr = 32'h3000; call = 1; ret = 1; cycle("callret");
        // misaligned ret target is impossible, but a misaligned call must not push
        sel_addr = 1; loaded_addr = 32'h3001; call = 1; cycle("call_mis");

        stall = 1; inc_pc = 1; sel_addr = 1; loaded_addr = 32'h40; cycle("stall");
        stall = 1; trap = 1; cycle("stall_trap");
        check("trap_pc", pc_res, TRAP);

        do_sel(32'hFFFF_FFFC, 0, "selwrap");
        inc_pc = 1; cycle("wrap");
        check("wrap_pc", pc_res, 32'h0);

        do_sel(32'h80, 1, "pre_rst");
        #3 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #1 reset_n = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            trap     = (r < 3);
            stall    = ($urandom_range(0, 9) == 0);
            sel_addr = ($urandom_range(0, 5) == 0);
            br_taken = ($urandom_range(0, 4) == 0);
            call     = ($urandom_range(0, 1) == 0);
            ret      = ($urandom_range(0, 3) == 0);
            inc_pc   = ($urandom_range(0, 1) == 0);
            loaded_addr = $urandom() & (($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
            incr = (32'($urandom_range(0, 64)) - 32'd32) << 2;
            if ($urandom_range(0, 7) == 0) incr = incr | 32'd2;
            cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
